display_chain_driver: RTL and testbench

//  Parametrised serial driver for a chain of HCMS-style 4-char dot-matrix displays.

---
 rtl/display_chain_driver_if.sv | 35 +++
 rtl/display_chain_driver.sv | 230 +++++++++++++++++++++++
 tb/tb_display_chain_driver.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_chain_driver_if.sv
// Frame handshake bundle between user logic and display_chain_driver.
// Optional macro DISP_BRIGHT_EN adds the runtime 4-bit brightness field.
interface display_chain_driver_if #(
  parameter int NUM_CHARS = 16
);
  localparam int DOTS = 40 * NUM_CHARS;

  logic [DOTS-1:0] dots;
  logic            load;
  logic            ready;
  logic            frame_done;
`ifdef DISP_BRIGHT_EN
  logic [3:0]      brightness;
`endif

  modport master (
    output dots,
    output load,
    input  ready,
    input  frame_done
`ifdef DISP_BRIGHT_EN
    , output brightness
`endif
  );

  modport slave (
    input  dots,
    input  load,
    output ready,
    output frame_done
`ifdef DISP_BRIGHT_EN
    , input  brightness
`endif
  );
endinterface

// File: rtl/display_chain_driver.sv
// Serial driver for a chain of HCMS-style 4-char dot-matrix displays, single clock domain.
// Optional macro DISP_BRIGHT_EN enables the runtime brightness control-word rewrite.
module display_chain_driver #(
  parameter int         NUM_CHARS  = 16,
  parameter int         CLK_HALF   = 27,
  parameter int         RST_CYCLES = 100,
  parameter logic [7:0] CTRL_WORD0 = 8'h7F
) (
  input  logic                   clock_27mhz,
  input  logic                   reset_b,
  display_chain_driver_if.slave  bus,
  output logic                   disp_blank,
  output logic                   disp_clock,
  output logic                   disp_rs,
  output logic                   disp_ce_b,
  output logic                   disp_reset_b,
  output logic                   disp_data_out
);
  localparam int DOTS      = 40 * NUM_CHARS;
  localparam int CTRL_BITS = 8 * (NUM_CHARS / 4);
  localparam int CNT_W     = $clog2(DOTS + 1);
  localparam int DIV_W     = $clog2(CLK_HALF);
  localparam int RCNT_W    = $clog2(RST_CYCLES + 1);

  localparam logic [CNT_W-1:0]  DOTS_C = CNT_W'(DOTS);
  localparam logic [CNT_W-1:0]  CTRL_C = CNT_W'(CTRL_BITS);
  localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(CLK_HALF - 1);
  localparam logic [RCNT_W-1:0] RST_TC = RCNT_W'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_RST_WAIT = 4'd0,
    ST_RST_END  = 4'd1,
    ST_CLR      = 4'd2,
    ST_LAT_CLR  = 4'd3,
    ST_CTRL     = 4'd4,
    ST_LAT_CTRL = 4'd5,
    ST_IDLE     = 4'd6,
    ST_SHIFT    = 4'd7,
    ST_LAT_DOT  = 4'd8
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic              r_phase;
  logic              r_disp_clock;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DOTS-1:0]   r_sreg, w_sreg_nxt;
  logic [RCNT_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic              r_ce_b, w_ce_b_nxt;
  logic              r_rs, w_rs_nxt;
  logic              r_data, w_data_nxt;
  logic              r_disp_reset_b, w_disp_reset_b_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_ready;
  logic              w_tick;
  logic              w_bright_chg;
  logic [7:0]        w_ctrl_word;
  logic [CTRL_BITS-1:0] w_ctrl_rep;
  logic [DOTS-1:0]   w_ctrl_sreg;
`ifdef DISP_BRIGHT_EN
  logic [3:0]        r_last_bright, w_last_bright_nxt;

  assign w_ctrl_word  = {2'b01, 2'b11, bus.brightness};
  assign w_bright_chg = (bus.brightness != r_last_bright);
`else
  assign w_ctrl_word  = CTRL_WORD0;
  assign w_bright_chg = 1'b0;
`endif

  assign w_ctrl_rep  = {(NUM_CHARS / 4){w_ctrl_word}};
  assign w_ctrl_sreg = {w_ctrl_rep, {(DOTS - CTRL_BITS){1'b0}}};
  // Pin updates happen only where phase goes 0->1, i.e. on the disp_clock falling edge.
  assign w_tick      = (r_div == DIV_TC) && !r_phase;

  // Half-period divider producing the display shift clock.
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      r_div        <= '0;
      r_phase      <= 1'b0;
      r_disp_clock <= 1'b1;
    end else if (r_div == DIV_TC) begin
      r_div        <= '0;
      r_phase      <= ~r_phase;
      r_disp_clock <= r_phase;
    end else begin
      r_div        <= r_div + DIV_W'(1);
    end
  end

  // Next-state and pin values; shift states emit one bit per tick until the count hits 0.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_sreg_nxt         = r_sreg;
    w_rst_cnt_nxt      = r_rst_cnt;
    w_ce_b_nxt         = r_ce_b;
    w_rs_nxt           = r_rs;
    w_data_nxt         = r_data;
    w_disp_reset_b_nxt = r_disp_reset_b;
    w_frame_done_nxt   = 1'b0;
`ifdef DISP_BRIGHT_EN
    w_last_bright_nxt  = r_last_bright;
`endif
    case (r_state)
      ST_RST_WAIT: begin
        w_disp_reset_b_nxt = 1'b0;
        if (r_rst_cnt == RST_TC) begin
          w_state_nxt = ST_RST_END;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RCNT_W'(1);
        end
      end
      ST_RST_END: begin
        w_disp_reset_b_nxt = 1'b1;
        w_cnt_nxt          = DOTS_C;
        w_sreg_nxt         = '0;
        w_state_nxt        = ST_CLR;
      end
      ST_CLR, ST_CTRL, ST_SHIFT: begin
        if (w_tick && (r_cnt != '0)) begin
          w_ce_b_nxt = 1'b0;
          w_rs_nxt   = (r_state == ST_CTRL);
          w_data_nxt = r_sreg[DOTS-1];
          w_sreg_nxt = {r_sreg[DOTS-2:0], 1'b0};
          w_cnt_nxt  = r_cnt - CNT_W'(1);
        end else if (w_tick) begin
          w_ce_b_nxt = 1'b1;
          w_data_nxt = 1'b0;
          case (r_state)
            ST_CLR:  w_state_nxt = ST_LAT_CLR;
            ST_CTRL: w_state_nxt = ST_LAT_CTRL;
            default: w_state_nxt = ST_LAT_DOT;
          endcase
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LAT_CLR: begin
        if (w_tick) begin
          w_state_nxt = ST_CTRL;
          w_cnt_nxt   = CTRL_C;
          w_sreg_nxt  = w_ctrl_sreg;
`ifdef DISP_BRIGHT_EN
          w_last_bright_nxt = bus.brightness;
`endif
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LAT_CTRL: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_rs_nxt    = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_IDLE: begin
        // A pending brightness rewrite wins over a load arriving in the same cycle.
        if (w_bright_chg) begin
          w_state_nxt = ST_CTRL;
          w_cnt_nxt   = CTRL_C;
          w_sreg_nxt  = w_ctrl_sreg;
`ifdef DISP_BRIGHT_EN
          w_last_bright_nxt = bus.brightness;
`endif
        end else if (bus.load) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = DOTS_C;
          w_sreg_nxt  = bus.dots;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LAT_DOT: begin
        if (w_tick) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_RST_WAIT;
      end
    endcase
  end

  // FSM, counters, shift register and registered pins.
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      r_state        <= ST_RST_WAIT;
      r_cnt          <= '0;
      r_sreg         <= '0;
      r_rst_cnt      <= '0;
      r_ce_b         <= 1'b1;
      r_rs           <= 1'b0;
      r_data         <= 1'b0;
      r_disp_reset_b <= 1'b0;
      r_frame_done   <= 1'b0;
      r_ready        <= 1'b0;
`ifdef DISP_BRIGHT_EN
      r_last_bright  <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_sreg         <= w_sreg_nxt;
      r_rst_cnt      <= w_rst_cnt_nxt;
      r_ce_b         <= w_ce_b_nxt;
      r_rs           <= w_rs_nxt;
      r_data         <= w_data_nxt;
      r_disp_reset_b <= w_disp_reset_b_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_ready        <= (w_state_nxt == ST_IDLE);
`ifdef DISP_BRIGHT_EN
      r_last_bright  <= w_last_bright_nxt;
`endif
    end
  end

  assign disp_blank     = 1'b0;
  assign disp_clock     = r_disp_clock;
  assign disp_rs        = r_rs;
  assign disp_ce_b      = r_ce_b;
  assign disp_reset_b   = r_disp_reset_b;
  assign disp_data_out  = r_data;
  assign bus.ready      = r_ready;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_chain_driver.sv
// Randomized bench for display_chain_driver: a segment-level model of what the chain must
// receive (init clear, control words, frames) is checked against every latched shift.
module tb_display_chain_driver;
  localparam int NC        = 8;
  localparam int CH        = 4;
  localparam int RC        = 100;
  localparam int DOTS      = 40 * NC;
  localparam int CTRL_BITS = 8 * (NC / 4);
  localparam int BOUND     = 20000;

  typedef struct {
    bit              rs;
    int              len;
    logic [DOTS-1:0] val;
    bit              frame;
  } seg_t;

  logic clk = 1'b0;
  logic reset_b;
  logic disp_blank, disp_clock, disp_rs, disp_ce_b, disp_reset_b, disp_data_out;

  display_chain_driver_if #(.NUM_CHARS(NC)) bus ();

  display_chain_driver #(
    .NUM_CHARS(NC), .CLK_HALF(CH), .RST_CYCLES(RC), .CTRL_WORD0(8'h7F)
  ) dut (
    .clock_27mhz   (clk),
    .reset_b       (reset_b),
    .bus           (bus.slave),
    .disp_blank    (disp_blank),
    .disp_clock    (disp_clock),
    .disp_rs       (disp_rs),
    .disp_ce_b     (disp_ce_b),
    .disp_reset_b  (disp_reset_b),
    .disp_data_out (disp_data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  seg_t exp_q[$];
  seg_t cur_e;
  logic [DOTS-1:0] cap_val, last_val;
  int   cap_len, last_len, nsegs, pending_done, done_cnt, rstb_cnt, half_cnt, frames_sent;
  bit   seg_active, cap_rs, cap_rs_bad, last_rs, rstb_done, half_known;
  bit   need_init = 1'b1;
  bit   prev_clk  = 1'b1;
  bit   prev_ce_b = 1'b1;
  logic [7:0] cur_word = 8'h7F;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [DOTS-1:0] act, input logic [DOTS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DOTS-1:0] ctrl_val(input logic [7:0] w);
    logic [DOTS-1:0] v = '0;
    for (int i = 0; i < NC / 4; i++) v[i*8 +: 8] = w;
    return v;
  endfunction

  function automatic seg_t mk(input bit rs, input int len, input logic [DOTS-1:0] val, input bit frame);
    seg_t s;
    s.rs = rs; s.len = len; s.val = val; s.frame = frame;
    return s;
  endfunction

  function automatic logic [DOTS-1:0] rand_dots();
    logic [DOTS-1:0] v = '0;
    for (int i = 0; i < DOTS / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Compare process: every sampled cycle is checked against the segment model.
  always @(negedge clk) begin
    if (!reset_b) begin
      chk("rst_pins", {disp_reset_b, disp_ce_b, disp_rs, disp_data_out, disp_clock,
                       bus.ready, bus.frame_done}, 7'b0100100);
      exp_q.delete();
      seg_active = 1'b0; cap_len = 0; pending_done = 0; need_init = 1'b1;
      rstb_cnt = 0; rstb_done = 1'b0; half_known = 1'b0; prev_clk = 1'b1; prev_ce_b = 1'b1;
    end else begin
      if (need_init) begin
        exp_q.push_back(mk(1'b0, DOTS, '0, 1'b0));
        exp_q.push_back(mk(1'b1, CTRL_BITS, ctrl_val(cur_word), 1'b0));
        need_init = 1'b0;
      end
      chk("blank", disp_blank, 1'b0);
      if (!rstb_done) begin
        if (disp_reset_b) begin
          chk("rstb_cycles", (rstb_cnt >= RC) && (rstb_cnt <= RC + 1), 1'b1);
          rstb_done = 1'b1;
        end else begin
          rstb_cnt++;
        end
      end
      if (disp_clock != prev_clk) begin
        if (half_known) chk("half_period", half_cnt, CH);
        half_known = 1'b1;
        half_cnt = 1;
      end else begin
        half_cnt++;
      end
      if (disp_clock && !prev_clk && !disp_ce_b) begin
        if (!seg_active) begin
          seg_active = 1'b1; cap_len = 0; cap_val = '0; cap_rs = disp_rs; cap_rs_bad = 1'b0;
        end
        if (disp_rs != cap_rs) cap_rs_bad = 1'b1;
        cap_val = {cap_val[DOTS-2:0], disp_data_out};
        cap_len++;
      end
      if (disp_ce_b && !prev_ce_b) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_seg", cap_len, 0);
        end else begin
          cur_e = exp_q.pop_front();
          chk("seg_len", cap_len, cur_e.len);
          chk("seg_rs", {cap_rs_bad, cap_rs}, {1'b0, cur_e.rs});
          chk_wide("seg_data", cap_val, cur_e.val);
          if (cur_e.frame) pending_done++;
        end
        last_val = cap_val; last_len = cap_len; last_rs = cap_rs;
        nsegs++;
        seg_active = 1'b0;
      end
      if (bus.frame_done) begin
        chk("fd_expected", pending_done > 0, 1'b1);
        if (pending_done > 0) pending_done--;
        done_cnt++;
      end
      if (bus.ready) chk("ready_idle", {exp_q.size() == 0, seg_active, pending_done == 0}, 3'b101);
      prev_clk  = disp_clock;
      prev_ce_b = disp_ce_b;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.ready && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    chk(name, bus.ready, 1'b1);
  endtask

  task automatic wait_bits(input int nb);
    int n = 0;
    while (!(seg_active && cap_len >= nb) && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bits_reached", seg_active && (cap_len >= nb), 1'b1);
  endtask

  task automatic send_frame(input logic [DOTS-1:0] d);
    wait_ready("ready_before_load");
    bus.dots = d;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    exp_q.push_back(mk(1'b0, DOTS, d, 1'b1));
    frames_sent++;
    chk("ready_after_load", bus.ready, 1'b0);
    bus.dots = rand_dots();
  endtask

  initial begin
    logic [DOTS-1:0] pat;
    int d0;
    reset_b = 1'b0;
    bus.load = 1'b0;
    bus.dots = '0;
`ifdef DISP_BRIGHT_EN
    bus.brightness = 4'hF;
`endif
    repeat (5) @(posedge clk);
    #1 reset_b = 1'b1;

    wait_ready("init_ready");
    chk("init_nsegs", nsegs, 2);
    chk("init_ctrl_len", last_len, 16);
    chk("init_ctrl_rs", last_rs, 1'b1);
    chk("init_ctrl_word", last_val[15:0], 16'h7F7F);

    pat = '0;
    pat[DOTS-1] = 1'b1;
    pat[0] = 1'b1;
    send_frame(pat);
    wait_ready("pat_ready");
    chk("pat_done", done_cnt, 1);
    chk("pat_len", last_len, 320);
    chk("pat_ones", $countones(last_val), 2);
    chk("pat_ends", {last_val[DOTS-1], last_val[0]}, 2'b11);

    send_frame(rand_dots());
    wait_bits(50);
    bus.dots = rand_dots();
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    wait_ready("ign_ready");
    chk("ign_done", done_cnt, 2);

    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send_frame(rand_dots());
      repeat ($urandom_range(1, 1500)) @(posedge clk);
      #1;
      bus.dots = rand_dots();
      bus.load = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
    end
    wait_ready("rand_ready");

`ifdef DISP_BRIGHT_EN
    d0 = done_cnt;
    bus.brightness = 4'h3;
    @(posedge clk); #1;
    cur_word = 8'h73;
    exp_q.push_back(mk(1'b1, CTRL_BITS, ctrl_val(cur_word), 1'b0));
    chk("bright_ready_low", bus.ready, 1'b0);
    wait_ready("bright_ready");
    chk("bright_word", last_val[15:0], 16'h7373);
    chk("bright_rs", last_rs, 1'b1);
    bus.brightness = 4'h5;
    bus.dots = rand_dots();
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    cur_word = 8'h75;
    exp_q.push_back(mk(1'b1, CTRL_BITS, ctrl_val(cur_word), 1'b0));
    wait_ready("bright_prio_ready");
    chk("bright_prio_word", last_val[15:0], 16'h7575);
    chk("bright_no_fd", done_cnt, d0);
`endif

    send_frame(rand_dots());
    wait_bits(300);
    reset_b = 1'b0;
    #1;
    chk("async_rst", {disp_reset_b, disp_ce_b, disp_rs, disp_data_out, disp_clock,
                      bus.ready, bus.frame_done}, 7'b0100100);
    frames_sent--;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1 reset_b = 1'b1;
    wait_ready("reinit_ready");
    chk("no_fd_after_rst", done_cnt, d0);

    send_frame(rand_dots());
    wait_ready("final_ready");
    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", exp_q.size(), 0);
    chk("pending_done", pending_done, 0);
    chk("frames_done", done_cnt, frames_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
